// File: rtl/prog_loader.sv
// Boot-time program loader: receives a LEN / payload / CSUM byte frame, writes the
// payload into cpu_8b instruction memory and releases the CPU once the checksum matches.
module prog_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              clr,
    input  logic              halt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        WAIT_LEN = 3'd0,
        DATA     = 3'd1,
        CSUM     = 3'd2,
        RUN      = 3'd3,
        ERR      = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        count;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;
    logic              accept;
    logic              len_bad;
    logic              last_byte;

    assign accept    = in_valid & in_ready;
    assign len_bad   = (in_data == 8'd0) || ({24'd0, in_data} > 32'(DEPTH));
    // Compare in 32 bits so a full-depth frame never relies on the address wrapping.
    assign last_byte = (32'(addr) + 32'd1) == {24'd0, count};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_LEN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LEN: begin
                if (clr)         state_nxt = WAIT_LEN;
                else if (accept) state_nxt = len_bad ? ERR : DATA;
            end
            DATA: begin
                if (clr)                         state_nxt = WAIT_LEN;
                else if (accept && last_byte)    state_nxt = CSUM;
            end
            CSUM: begin
                if (clr)         state_nxt = WAIT_LEN;
                else if (accept) state_nxt = (in_data == sum) ? RUN : ERR;
            end
            RUN: begin
                if (halt) state_nxt = WAIT_LEN;
            end
            ERR: begin
                if (clr) state_nxt = WAIT_LEN;
            end
            default: state_nxt = WAIT_LEN;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            WAIT_LEN, DATA, CSUM: in_ready = ~rst;
            RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    // Write port is registered: an accepted payload byte appears on the memory bus one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= 8'd0;
            count     <= 8'd0;
            addr      <= '0;
            sum       <= 8'd0;
        end else begin
            mem_we <= 1'b0;
            if (clr && state != RUN) begin
                count <= 8'd0;
                addr  <= '0;
                sum   <= 8'd0;
            end else if (accept) begin
                case (state)
                    WAIT_LEN: begin
                        count <= in_data;
                        addr  <= '0;
                        sum   <= 8'd0;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_waddr <= addr;
                        mem_wdata <= in_data;
                        sum       <= sum + in_data;
                        addr      <= addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: each step drives the inputs, advances one clock
// and compares outputs against hand-computed values.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       clr;
    logic       halt;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       cpu_rst;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    prog_loader #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clr(clr), .halt(halt), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one byte (or idle), clock it, then check the resulting write port.
    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic we, input logic [3:0] a, input logic [7:0] wd);
        in_valid = v;
        in_data  = d;
        tick();
        chk({tag, ".we"}, 32'(mem_we), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(mem_waddr), 32'(a));
            chk({tag, ".data"}, 32'(mem_wdata), 32'(wd));
        end
    endtask

    task automatic chk_status(input string tag, input logic rdy, input logic cr,
                              input logic dn, input logic er);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".cpu_rst"},  32'(cpu_rst),  32'(cr));
        chk({tag, ".done"},     32'(done),     32'(dn));
        chk({tag, ".err"},      32'(err),      32'(er));
    endtask

    task automatic do_halt(input string tag);
        in_valid = 1'b0;
        halt     = 1'b1;
        tick();
        halt = 1'b0;
        chk_status(tag, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clr(input string tag);
        in_valid = 1'b0;
        clr      = 1'b1;
        tick();
        clr = 1'b0;
        chk_status(tag, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; clr = 1'b0; halt = 1'b0;
        tick();
        tick();
        chk_status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.we", 32'(mem_we), 32'd0);
        chk("reset.addr", 32'(mem_waddr), 32'd0);
        chk("reset.data", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        #1;
        chk_status("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Continuous frame {03,11,22,33,66}
        step("f1.len", 1'b1, 8'h03, 1'b0, 4'd0, 8'h00);
        step("f1.b0",  1'b1, 8'h11, 1'b1, 4'd0, 8'h11);
        step("f1.b1",  1'b1, 8'h22, 1'b1, 4'd1, 8'h22);
        step("f1.b2",  1'b1, 8'h33, 1'b1, 4'd2, 8'h33);
        step("f1.cs",  1'b1, 8'h66, 1'b0, 4'd0, 8'h00);
        chk_status("f1.run", 1'b0, 1'b0, 1'b1, 1'b0);
        step("f1.hold", 1'b1, 8'h55, 1'b0, 4'd0, 8'h00);
        chk_status("f1.run2", 1'b0, 1'b0, 1'b1, 1'b0);

        // clr has no effect in RUN; halt re-arms; reload {01,0A,0A}
        clr = 1'b1;
        step("runclr", 1'b0, 8'h00, 1'b0, 4'd0, 8'h00);
        clr = 1'b0;
        chk_status("runclr", 1'b0, 1'b0, 1'b1, 1'b0);
        do_halt("halt1");
        step("f2.len", 1'b1, 8'h01, 1'b0, 4'd0, 8'h00);
        step("f2.b0",  1'b1, 8'h0A, 1'b1, 4'd0, 8'h0A);
        step("f2.cs",  1'b1, 8'h0A, 1'b0, 4'd0, 8'h00);
        chk_status("f2.run", 1'b0, 1'b0, 1'b1, 1'b0);
        do_halt("halt2");

        // Checksum mismatch {02,FF,02,00}: sum wraps to 01
        step("f3.len", 1'b1, 8'h02, 1'b0, 4'd0, 8'h00);
        step("f3.b0",  1'b1, 8'hFF, 1'b1, 4'd0, 8'hFF);
        step("f3.b1",  1'b1, 8'h02, 1'b1, 4'd1, 8'h02);
        step("f3.cs",  1'b1, 8'h00, 1'b0, 4'd0, 8'h00);
        chk_status("f3.err", 1'b0, 1'b1, 1'b0, 1'b1);
        halt = 1'b1;
        step("f3.sticky", 1'b1, 8'h01, 1'b0, 4'd0, 8'h00);
        halt = 1'b0;
        chk_status("f3.sticky", 1'b0, 1'b1, 1'b0, 1'b1);
        do_clr("f3.clr");

        // Illegal lengths
        step("len0", 1'b1, 8'h00, 1'b0, 4'd0, 8'h00);
        chk_status("len0", 1'b0, 1'b1, 1'b0, 1'b1);
        step("len0.idle", 1'b0, 8'h00, 1'b0, 4'd0, 8'h00);
        do_clr("len0.clr");
        step("len17", 1'b1, 8'd17, 1'b0, 4'd0, 8'h00);
        chk_status("len17", 1'b0, 1'b1, 1'b0, 1'b1);
        step("len17.idle", 1'b0, 8'h00, 1'b0, 4'd0, 8'h00);
        do_clr("len17.clr");

        // Full-depth frame: 16 bytes 01..10, sum = 0x88
        step("f16.len", 1'b1, 8'd16, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 16; i++)
            step("f16.b", 1'b1, 8'(i + 1), 1'b1, 4'(i), 8'(i + 1));
        chk_status("f16.csum", 1'b1, 1'b1, 1'b0, 1'b0);
        step("f16.cs", 1'b1, 8'h88, 1'b0, 4'd0, 8'h00);
        chk_status("f16.run", 1'b0, 1'b0, 1'b1, 1'b0);
        do_halt("halt3");

        // Frame 1 again with in_valid toggling every cycle
        step("t.len", 1'b1, 8'h03, 1'b0, 4'd0, 8'h00);
        step("t.g0",  1'b0, 8'hEE, 1'b0, 4'd0, 8'h00);
        step("t.b0",  1'b1, 8'h11, 1'b1, 4'd0, 8'h11);
        step("t.g1",  1'b0, 8'hEE, 1'b0, 4'd0, 8'h00);
        step("t.b1",  1'b1, 8'h22, 1'b1, 4'd1, 8'h22);
        step("t.g2",  1'b0, 8'hEE, 1'b0, 4'd0, 8'h00);
        step("t.b2",  1'b1, 8'h33, 1'b1, 4'd2, 8'h33);
        step("t.g3",  1'b0, 8'hEE, 1'b0, 4'd0, 8'h00);
        chk_status("t.csum", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t.cs",  1'b1, 8'h66, 1'b0, 4'd0, 8'h00);
        chk_status("t.run", 1'b0, 1'b0, 1'b1, 1'b0);
        do_halt("halt4");

        // rst mid-frame after 2 of 4 payload bytes
        step("r.len", 1'b1, 8'h04, 1'b0, 4'd0, 8'h00);
        step("r.b0",  1'b1, 8'h01, 1'b1, 4'd0, 8'h01);
        step("r.b1",  1'b1, 8'h02, 1'b1, 4'd1, 8'h02);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_status("r.async", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("r.async.we", 32'(mem_we), 32'd0);
        chk("r.async.addr", 32'(mem_waddr), 32'd0);
        chk("r.async.data", 32'(mem_wdata), 32'd0);
        tick();
        rst = 1'b0;
        step("r2.len", 1'b1, 8'h01, 1'b0, 4'd0, 8'h00);
        step("r2.b0",  1'b1, 8'h5A, 1'b1, 4'd0, 8'h5A);
        step("r2.cs",  1'b1, 8'h5A, 1'b0, 4'd0, 8'h00);
        chk_status("r2.run", 1'b0, 1'b0, 1'b1, 1'b0);
        do_halt("halt5");

        // clr coincident with a DATA accept drops the byte and restarts framing
        step("c.len", 1'b1, 8'h02, 1'b0, 4'd0, 8'h00);
        clr = 1'b1;
        step("c.drop", 1'b1, 8'hAA, 1'b0, 4'd0, 8'h00);
        clr = 1'b0;
        chk_status("c.drop", 1'b1, 1'b1, 1'b0, 1'b0);
        step("c2.len", 1'b1, 8'h01, 1'b0, 4'd0, 8'h00);
        step("c2.b0",  1'b1, 8'hBB, 1'b1, 4'd0, 8'hBB);
        step("c2.cs",  1'b1, 8'hBB, 1'b0, 4'd0, 8'h00);
        chk_status("c2.run", 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of cpu_8b. It receives a framed byte stream over a valid/ready handshake and writes the payload into the CPU instruction memory. It holds the CPU in reset until a complete frame with a correct checksum has been loaded. On CPU halt it re-arms for the next program.

Parameters:
ADDR_W, 4, instruction memory address width; DEPTH = 2**ADDR_W words of 8 bits.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream byte valid
in_data  input  8  upstream byte
in_ready  output  1  loader can accept a byte this cycle
clr  input  1  synchronous abort/clear pulse
halt  input  1  halt flag from cpu_8b
mem_we  output  1  instruction memory write enable, one-cycle pulse per byte
mem_waddr  output  ADDR_W  instruction memory write address
mem_wdata  output  8  instruction memory write data
cpu_rst  output  1  reset to cpu_8b, active-high
done  output  1  program loaded and CPU released
err  output  1  frame error, sticky

Behaviour:
- Reset is asynchronous and active-high on rst, clocked on rising clk. While rst=1:
  - state=WAIT_LEN, mem_we=0, mem_waddr=0, mem_wdata=0.
  - cpu_rst=1, done=0, err=0; count, addr and sum are 0.
  - in_ready is forced to 0.
- Frame format: LEN byte N, then N payload bytes, then CSUM byte = (sum of payload) mod 256.
- A byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_valid without in_ready is ignored; upstream holds the byte.
- in_ready=1 in WAIT_LEN, DATA and CSUM. in_ready=0 in RUN and ERR.
- WAIT_LEN, on accept:
  - N==0 or N>DEPTH -> ERR.
  - Otherwise count<=N, addr<=0, sum<=0 -> DATA.
- DATA, on accept:
  - Next cycle: mem_we=1, mem_waddr=addr, mem_wdata=in_data (registered, 1-cycle latency).
  - sum<=sum+in_data (8-bit wrap); addr<=addr+1.
  - When the accepted byte is number N (addr==N-1) -> CSUM.
  - mem_we=0 on every cycle without an accepted DATA byte.
- CSUM, on accept:
  - in_data==sum -> RUN. Next cycle cpu_rst=0 and done=1.
  - Mismatch -> ERR. Next cycle err=1; cpu_rst stays 1.
  - No memory write occurs for the checksum byte.
- RUN:
  - cpu_rst=0, done=1.
  - halt=1 -> WAIT_LEN. Next cycle cpu_rst=1, done=0 (ready for a reload).
- ERR:
  - err=1, cpu_rst=1. Leaves only on clr or rst.
- clr=1:
  - In WAIT_LEN, DATA, CSUM or ERR -> WAIT_LEN. err<=0, count, addr and sum cleared, cpu_rst=1.
  - clr takes priority over a simultaneous byte accept; that byte is dropped and not written.
  - clr in RUN is ignored.
- halt is ignored outside RUN.
- Maximum frame N==DEPTH: the last write goes to address DEPTH-1. The addr wrap to 0 is never used.
- rst asserted mid-frame: immediate return to reset values. Memory words already written are not erased.
- Back-to-back accepts (in_valid held high) are supported at one byte per cycle, with no bubble between frame fields.
- done and err are never 1 simultaneously.

Test Plan:
- Reset then frame {03, 11, 22, 33, 66}, in_valid continuous -> mem_we pulses at addresses 0, 1, 2 with data 11, 22, 33 on consecutive cycles. One cycle after the checksum is accepted: cpu_rst=0, done=1, in_ready=0.
- Frame {02, FF, 02, 00} (sum wraps to 01) -> checksum mismatch: err=1, cpu_rst=1, in_ready=0. Then a clr pulse -> err=0, in_ready=1, state WAIT_LEN.
- LEN=00, and separately LEN=17 with ADDR_W=4 -> ERR immediately, with no mem_we pulse.
- Valid frame with in_valid toggled 1/0 every cycle -> writes occur only on accepted cycles, at the same addresses and data as the continuous case.
- In RUN, halt=1 for one cycle -> cpu_rst=1 and done=0 on the next cycle. Reloading frame {01, 0A, 0A} -> address 0 written with 0A, CPU released again.
- rst pulsed after 2 of 4 payload bytes -> all outputs return to reset values. A fresh frame then loads from address 0. clr coincident with a DATA accept -> no mem_we for that byte.
